// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction/state types and step-period helper for the step sequencer
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_WAIT,
        S_PAUSE,
        S_OVER
    } seq_state_t;

    // frames per step: shrinks by one per level but never below frames_min
    function automatic int unsigned step_period(input int unsigned level,
                                                input int unsigned frames_init,
                                                input int unsigned frames_min);
        if (level + frames_min >= frames_init) return frames_min;
        else                                   return frames_init - level;
    endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// rtl/step_sequencer_if.sv - step request/done handshake between sequencer and snake datapath
interface step_sequencer_if;
    import snake_pkg::*;

    logic step;
    dir_t step_dir;
    logic clear;
    logic step_done;
    logic collision;
    logic apple;

    modport master (output step, step_dir, clear, input step_done, collision, apple);
    modport slave  (input step, step_dir, clear, output step_done, collision, apple);
endinterface

// File: rtl/step_timer.sv
// rtl/step_timer.sv - frame counter with level-dependent period compare, emits a fire pulse
module step_timer
    import snake_pkg::*;
#(
    parameter int FRAMES_INIT = 8,
    parameter int FRAMES_MIN  = 2,
    parameter int LEVEL_W     = 3,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LEVEL_W-1:0] i_level,
    input  logic               i_frame,
    input  logic               i_enable,
    input  logic               i_clear,
    output logic               o_fire
);
    logic [CNT_W-1:0] r_frame_cnt;
    logic [31:0]      w_period;
    logic [31:0]      w_next_cnt;
    logic             w_count;

    // compare against the post-increment count; >= covers a level change that shrank the period mid-count
    assign w_period   = step_period(32'(i_level), FRAMES_INIT, FRAMES_MIN);
    assign w_count    = i_enable & i_frame;
    assign w_next_cnt = 32'(r_frame_cnt) + 32'd1;
    assign o_fire     = w_count & (w_next_cnt >= w_period);

    // frame counter: cleared by the sequencer, advanced by counted frames, wrapped on fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_frame_cnt <= '0;
        else if (i_clear)  r_frame_cnt <= '0;
        else if (o_fire)   r_frame_cnt <= '0;
        else if (w_count)  r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - game-step scheduler; optional pause support under SNAKE_PAUSE_EN
module step_sequencer
    import snake_pkg::*;
#(
    parameter int FRAMES_INIT      = 8,
    parameter int FRAMES_MIN       = 2,
    parameter int APPLES_PER_LEVEL = 4,
    parameter int LEVEL_W          = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [1:0]         i_dir,
    input  logic               i_frame,
    input  logic               i_pause,
    input  logic               i_restart,
    step_sequencer_if.master   dp,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_running,
    output logic               o_paused,
    output logic               o_game_over
);
    localparam int APPLE_W = (APPLES_PER_LEVEL > 1) ? $clog2(APPLES_PER_LEVEL) : 1;

    seq_state_t         r_state;
    seq_state_t         w_next;
    dir_t               r_dir;
    logic [LEVEL_W-1:0] r_level;
    logic [APPLE_W-1:0] r_apple_cnt;
    logic               w_fire;
    logic               w_timer_en;
    logic               w_timer_clr;
    logic               w_clear;
    logic               w_apple_hit;
    logic               w_pause_req;
    logic               w_pause_go;

`ifdef SNAKE_PAUSE_EN
    logic r_pause_pend;

    assign w_pause_req = i_pause;
    assign w_pause_go  = r_pause_pend | i_pause;

    // remember a pause request that arrives while a step is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   r_pause_pend <= 1'b0;
        else if (r_state == S_WAIT && dp.step_done)   r_pause_pend <= 1'b0;
        else if ((r_state == S_STEP || r_state == S_WAIT) && i_pause)
                                                      r_pause_pend <= 1'b1;
    end

    assign o_paused = (r_state == S_PAUSE);
`else
    logic w_unused_pause;

    assign w_unused_pause = i_pause;
    assign w_pause_req    = 1'b0;
    assign w_pause_go     = 1'b0;
    assign o_paused       = 1'b0;
`endif

    // a pause request in RUN wins over a same-cycle frame, so that frame is dropped
    assign w_timer_en  = (r_state == S_RUN) & ~w_pause_req;
    assign w_timer_clr = (r_state == S_IDLE) | w_clear;

    step_timer #(
        .FRAMES_INIT (FRAMES_INIT),
        .FRAMES_MIN  (FRAMES_MIN),
        .LEVEL_W     (LEVEL_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_level  (r_level),
        .i_frame  (i_frame),
        .i_enable (w_timer_en),
        .i_clear  (w_timer_clr),
        .o_fire   (w_fire)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next-state logic, restart clear pulse and apple qualification
    always_comb begin
        w_next      = r_state;
        w_clear     = 1'b0;
        w_apple_hit = 1'b0;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_RUN;
            S_RUN: begin
                if (w_pause_req) w_next = S_PAUSE;
                else if (w_fire) w_next = S_STEP;
            end
            S_STEP:  w_next = S_WAIT;
            S_WAIT: begin
                if (dp.step_done) begin
                    if (dp.collision) begin
                        w_next = S_OVER;
                    end else begin
                        w_apple_hit = dp.apple;
                        w_next      = w_pause_go ? S_PAUSE : S_RUN;
                    end
                end
            end
            S_PAUSE: if (w_pause_req) w_next = S_RUN;
            S_OVER: begin
                if (i_restart) begin
                    w_clear = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // latch the player direction during the step request cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_dir <= DIR_UP;
        else if (r_state == S_STEP) r_dir <= dir_t'(i_dir);
    end

    // apple tally and speed level; level saturates at its top value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level     <= '0;
            r_apple_cnt <= '0;
        end else if (w_clear) begin
            r_level     <= '0;
            r_apple_cnt <= '0;
        end else if (w_apple_hit) begin
            if (r_apple_cnt == APPLE_W'(APPLES_PER_LEVEL - 1)) begin
                r_apple_cnt <= '0;
                if (r_level != {LEVEL_W{1'b1}}) r_level <= r_level + LEVEL_W'(1);
            end else begin
                r_apple_cnt <= r_apple_cnt + APPLE_W'(1);
            end
        end
    end

    assign dp.step      = (r_state == S_STEP);
    assign dp.step_dir  = r_dir;
    assign dp.clear     = w_clear;
    assign o_level      = r_level;
    assign o_running    = (r_state == S_RUN) | (r_state == S_STEP) | (r_state == S_WAIT);
    assign o_game_over  = (r_state == S_OVER);
endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - randomized self-checking bench for step_sequencer
module tb_step_sequencer;
    import snake_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic [1:0] i_dir;
    logic       i_frame;
    logic       i_pause;
    logic       i_restart;
    logic [2:0] o_level;
    logic       o_running;
    logic       o_paused;
    logic       o_game_over;

    int n_checks = 0;
    int n_pass   = 0;

    int         m_level  = 0;
    int         m_apples = 0;
    logic [1:0] m_dir    = 2'b00;

    step_sequencer_if u_if ();

    step_sequencer #(
        .FRAMES_INIT      (8),
        .FRAMES_MIN       (2),
        .APPLES_PER_LEVEL (4),
        .LEVEL_W          (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_dir       (i_dir),
        .i_frame     (i_frame),
        .i_pause     (i_pause),
        .i_restart   (i_restart),
        .dp          (u_if.master),
        .o_level     (o_level),
        .o_running   (o_running),
        .o_paused    (o_paused),
        .o_game_over (o_game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int period();
        return (8 - m_level > 2) ? 8 - m_level : 2;
    endfunction

    // deliver frames until the step fires; 'already' frames were counted earlier
    task automatic frames_to_step(input int already, input logic [1:0] dir);
        int p;
        p     = period();
        i_dir = dir;
        for (int f = already + 1; f <= p; f++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("early_step_gap", 32'(u_if.step), 32'd0);
            end
            i_frame = 1'b1;
            @(negedge clk);
            i_frame = 1'b0;
            if (f < p) chk("early_step", 32'(u_if.step), 32'd0);
            else       chk("step_after_frame", 32'(u_if.step), 32'd1);
        end
        @(negedge clk);
        m_dir = dir;
        chk("step_dir", 32'(u_if.step_dir), 32'(m_dir));
        chk("step_one_cycle", 32'(u_if.step), 32'd0);
        chk("running_wait", 32'(o_running), 32'd1);
        i_dir = 2'($urandom);
    endtask

    // answer the outstanding step after a random delay and update the model
    task automatic finish_step(input logic apple, input logic coll);
        i_restart = 1'b1;
        #1;
        chk("restart_ignored", 32'(u_if.clear), 32'd0);
        @(negedge clk);
        i_restart = 1'b0;
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            chk("dir_stable", 32'(u_if.step_dir), 32'(m_dir));
            chk("no_step_wait", 32'(u_if.step), 32'd0);
        end
        u_if.step_done = 1'b1;
        u_if.apple     = apple;
        u_if.collision = coll;
        @(negedge clk);
        u_if.step_done = 1'b0;
        u_if.apple     = 1'b0;
        u_if.collision = 1'b0;
        if (!coll && apple) begin
            m_apples++;
            if (m_apples == 4) begin
                m_apples = 0;
                if (m_level < 7) m_level++;
            end
        end
        chk("level", 32'(o_level), 32'(m_level));
        chk("game_over", 32'(o_game_over), 32'(coll));
        chk("running", 32'(o_running), 32'(!coll));
    endtask

    initial begin
        rst_n          = 1'b0;
        i_start        = 1'b0;
        i_dir          = 2'b00;
        i_frame        = 1'b0;
        i_pause        = 1'b0;
        i_restart      = 1'b0;
        u_if.step_done = 1'b0;
        u_if.collision = 1'b0;
        u_if.apple     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_step", 32'(u_if.step), 32'd0);
        chk("rst_dir", 32'(u_if.step_dir), 32'd0);
        chk("rst_clear", 32'(u_if.clear), 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_running", 32'(o_running), 32'd0);
        chk("rst_paused", 32'(o_paused), 32'd0);
        chk("rst_over", 32'(o_game_over), 32'd0);
        rst_n = 1'b1;

        // frames while idle must not count toward the first step
        repeat (3) begin
            i_frame = 1'b1;
            @(negedge clk);
            i_frame = 1'b0;
            @(negedge clk);
            chk("idle_no_step", 32'(u_if.step), 32'd0);
            chk("idle_not_running", 32'(o_running), 32'd0);
        end
        i_start = 1'b1;
        @(negedge clk);
        chk("run_after_start", 32'(o_running), 32'd1);

        // first level: four apples
        frames_to_step(0, 2'b11);
        finish_step(1'b1, 1'b0);
        repeat (3) begin
            frames_to_step(0, 2'($urandom));
            finish_step(1'b1, 1'b0);
        end
        chk("level_one", 32'(o_level), 32'd1);

        // mixed apples up to saturation, then a few more steps at the floor period
        while (m_level < 7) begin
            frames_to_step(0, 2'($urandom));
            finish_step(1'($urandom_range(0, 3) != 0), 1'b0);
        end
        repeat (4) begin
            frames_to_step(0, 2'($urandom));
            finish_step(1'($urandom), 1'b0);
        end
        chk("level_sat", 32'(o_level), 32'd7);

        // collision beats apple
        frames_to_step(0, 2'($urandom));
        finish_step(1'b1, 1'b1);
        chk("over_level_kept", 32'(o_level), 32'd7);
        i_start = 1'b0;
        repeat (4) begin
            i_frame        = 1'b1;
            u_if.step_done = 1'($urandom);
            u_if.apple     = 1'b1;
            @(negedge clk);
            i_frame        = 1'b0;
            u_if.step_done = 1'b0;
            u_if.apple     = 1'b0;
            @(negedge clk);
            chk("over_no_step", 32'(u_if.step), 32'd0);
            chk("over_held", 32'(o_game_over), 32'd1);
        end
        chk("over_level_stable", 32'(o_level), 32'd7);
        i_restart = 1'b1;
        #1;
        chk("clear_pulse", 32'(u_if.clear), 32'd1);
        @(negedge clk);
        i_restart = 1'b0;
        m_level   = 0;
        m_apples  = 0;
        chk("clear_one_cycle", 32'(u_if.clear), 32'd0);
        chk("restart_level", 32'(o_level), 32'd0);
        chk("restart_over", 32'(o_game_over), 32'd0);
        chk("restart_idle", 32'(o_running), 32'd0);

        // new game at level 0 must use the full period again
        i_start = 1'b1;
        @(negedge clk);
        frames_to_step(0, 2'b10);
        finish_step(1'b1, 1'b0);

`ifdef SNAKE_PAUSE_EN
        repeat (2) begin
            i_frame = 1'b1;
            @(negedge clk);
            i_frame = 1'b0;
            @(negedge clk);
        end
        i_pause = 1'b1;
        i_frame = 1'b1;
        @(negedge clk);
        i_pause = 1'b0;
        i_frame = 1'b0;
        chk("paused", 32'(o_paused), 32'd1);
        chk("paused_not_running", 32'(o_running), 32'd0);
        repeat (6) begin
            i_frame = 1'b1;
            @(negedge clk);
            i_frame = 1'b0;
            chk("pause_no_step", 32'(u_if.step), 32'd0);
        end
        i_pause = 1'b1;
        @(negedge clk);
        i_pause = 1'b0;
        chk("resumed", 32'(o_paused), 32'd0);
        frames_to_step(2, 2'b01);
        i_pause = 1'b1;
        @(negedge clk);
        i_pause = 1'b0;
        u_if.step_done = 1'b1;
        @(negedge clk);
        u_if.step_done = 1'b0;
        chk("pend_pause", 32'(o_paused), 32'd1);
        i_pause = 1'b1;
        @(negedge clk);
        i_pause = 1'b0;
        chk("pend_resume", 32'(o_running), 32'd1);
`endif

        // asynchronous reset in the middle of a step
        frames_to_step(0, 2'b01);
        i_start = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_step_dir", 32'(u_if.step_dir), 32'd0);
        chk("arst_running", 32'(o_running), 32'd0);
        chk("arst_level", 32'(o_level), 32'd0);
        chk("arst_over", 32'(o_game_over), 32'd0);
        chk("arst_paused", 32'(o_paused), 32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        m_level        = 0;
        m_apples       = 0;
        u_if.step_done = 1'b1;
        u_if.apple     = 1'b1;
        @(negedge clk);
        u_if.step_done = 1'b0;
        u_if.apple     = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_done_step", 32'(u_if.step), 32'd0);
            chk("late_done_running", 32'(o_running), 32'd0);
            chk("late_done_level", 32'(o_level), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
